de1_pio: RTL

DE1_PIO -- requirements
Module: de1_pio

---
 rtl/de1_pio_pkg.sv | 16 +
 rtl/de1_pio_debounce.sv | 59 +++++
 rtl/de1_pio.sv | 119 +++++++++++
 3 files changed

// File: rtl/de1_pio_pkg.sv
// Shared constants for the DE1 parallel I/O block: Avalon register word
// addresses and the edge-capture mode encoding.
package de1_pio_pkg;

  localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
  localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
  localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/de1_pio_debounce.sv
// One input pin: 2-flop synchroniser followed, when DE1_PIO_DEBOUNCE_EN is
// defined, by a consecutive-cycle debounce counter and stable-value flop.
module de1_pio_debounce import de1_pio_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic stable_o
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("de1_pio_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  logic sync1_q;
  logic sync2_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, which is what makes the two stages a chain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef DE1_PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          stable_q;

  // The count tracks how long the synchronised value has disagreed with the
  // stable value; any agreement (a glitch back) restarts it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (sync2_q == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q    <= '0;
      stable_q <= sync2_q;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign stable_o = stable_q;
`else
  assign stable_o = sync2_q;
`endif

endmodule

// File: rtl/de1_pio.sv
// Avalon-MM parallel I/O port with edge capture and level interrupt.
// Define DE1_PIO_DEBOUNCE_EN to add per-bit input debouncing.
module de1_pio import de1_pio_pkg::*; #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             readdatavalid,
  output logic             irq,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] pio_out
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("de1_pio: WIDTH must be in 1..32");
  end

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_prev_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [31:0]      rd_mux;
  logic [31:0]      readdata_q;
  logic             readdatavalid_q;
  logic             irq_q;
  logic             rd_fire;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    de1_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .pin_i   (pio_in[i]),
      .stable_o(stable[i])
    );
  end

  if (WIDTH < 32) begin : g_unused_hi
    logic unused_writedata_hi;
    assign unused_writedata_hi = |writedata[31:WIDTH];
  end

  assign wdata   = writedata[WIDTH-1:0];
  // A simultaneous write takes priority; the read is dropped.
  assign rd_fire = read & ~write;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    edge_det   = stable & ~stable_prev_q;
    data_out_d = data_out_q;
    irq_mask_d = irq_mask_q;
    w1c        = '0;
    rd_mux     = '0;

    if (EDGE_TYPE == EDGE_FALLING) edge_det = ~stable & stable_prev_q;
    else if (EDGE_TYPE == EDGE_ANY) edge_det = stable ^ stable_prev_q;

    if (write) begin
      case (address)
        ADDR_DATA_OUT: data_out_d = wdata;
        ADDR_IRQ_MASK: irq_mask_d = wdata;
        ADDR_EDGE_CAP: w1c        = wdata;
        ADDR_OUT_SET:  data_out_d = data_out_q | wdata;
        ADDR_OUT_CLR:  data_out_d = data_out_q & ~wdata;
        default: ;
      endcase
    end

    // A new edge overrides a same-cycle clear of that bit.
    edge_cap_d = (edge_cap_q & ~w1c) | edge_det;

    case (address)
      ADDR_DATA_IN:  rd_mux = 32'(stable);
      ADDR_DATA_OUT: rd_mux = 32'(data_out_q);
      ADDR_IRQ_MASK: rd_mux = 32'(irq_mask_q);
      ADDR_EDGE_CAP: rd_mux = 32'(edge_cap_q);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable_prev_q   <= '0;
      data_out_q      <= '0;
      irq_mask_q      <= '0;
      edge_cap_q      <= '0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      irq_q           <= 1'b0;
    end else begin
      stable_prev_q   <= stable;
      data_out_q      <= data_out_d;
      irq_mask_q      <= irq_mask_d;
      edge_cap_q      <= edge_cap_d;
      readdata_q      <= rd_fire ? rd_mux : '0;
      readdatavalid_q <= rd_fire;
      irq_q           <= |(edge_cap_q & irq_mask_q);
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;
  assign irq           = irq_q;
  assign pio_out       = data_out_q;

endmodule
